// File: rtl/address_pointer.sv
// ---------------------------------------------------------------------------
// address_pointer
//   16-bit loadable up/down address register. Serves as stack pointer,
//   memory pointer or index register feeding the address calculator.
//   Loads a full word from abus, or single bytes from mbus; counts up or
//   down by STEP; drives its value onto abus, or either byte onto mbus,
//   through tri-state outputs.
//
// Parameters
//   RESET_VALUE  register value after reset
//   STEP         increment/decrement amount per counting edge (1..255)
//
// Ports
//   clk       system clock, rising-edge active
//   resetn    asynchronous active-low reset
//   abus      16-bit address bus (inout), driven while outn=0
//   mbus      8-bit main data bus (inout), driven while lo_outn=0 or hi_outn=0
//   loadn     load ptr from abus
//   lo_loadn  load ptr[7:0] from mbus
//   hi_loadn  load ptr[15:8] from mbus
//   incn      ptr <= ptr + STEP
//   decn      ptr <= ptr - STEP
//   outn      drive ptr onto abus
//   lo_outn   drive ptr[7:0] onto mbus (wins over hi_outn)
//   hi_outn   drive ptr[15:8] onto mbus
//   wrapped   (ADDRESS_POINTER_WRAP_FLAG_EN only) sticky wrap-around flag,
//             cleared by any load
//
// Optional feature macro: ADDRESS_POINTER_WRAP_FLAG_EN
// ---------------------------------------------------------------------------
module address_pointer #(
  parameter logic [15:0] RESET_VALUE = 16'h0000,
  parameter int unsigned STEP        = 1
) (
  input  logic        clk,
  input  logic        resetn,
  inout  wire  [15:0] abus,
  inout  wire  [7:0]  mbus,
  input  logic        loadn,
  input  logic        lo_loadn,
  input  logic        hi_loadn,
  input  logic        incn,
  input  logic        decn,
  input  logic        outn,
  input  logic        lo_outn,
  input  logic        hi_outn
`ifdef ADDRESS_POINTER_WRAP_FLAG_EN
  ,
  output logic        wrapped
`endif
);

  localparam logic [7:0]  STEP_B = STEP[7:0];
  localparam logic [16:0] STEP_X = {9'b0, STEP_B};

  logic [15:0] ptr;
  logic [15:0] ptr_nxt;
  logic        do_inc;
  logic        do_dec;

  // Word load has highest priority, then byte loads, then counting.
  assign do_inc = loadn && lo_loadn && hi_loadn && !incn &&  decn;
  assign do_dec = loadn && lo_loadn && hi_loadn &&  incn && !decn;

`ifdef ADDRESS_POINTER_WRAP_FLAG_EN
  // One extra bit carries the carry/borrow out of bit 15.
  logic [16:0] inc_val;
  logic [16:0] dec_val;
  assign inc_val = {1'b0, ptr} + STEP_X;
  assign dec_val = {1'b0, ptr} - STEP_X;
`else
  logic [15:0] inc_val;
  logic [15:0] dec_val;
  assign inc_val = ptr + STEP_X[15:0];
  assign dec_val = ptr - STEP_X[15:0];
`endif

  always_comb begin
    ptr_nxt = ptr;
    if (!loadn) begin
      ptr_nxt = abus;
    end else if (!lo_loadn || !hi_loadn) begin
      if (!lo_loadn) ptr_nxt[7:0]  = mbus;
      if (!hi_loadn) ptr_nxt[15:8] = mbus;
    end else if (do_inc) begin
      ptr_nxt = inc_val[15:0];
    end else if (do_dec) begin
      ptr_nxt = dec_val[15:0];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) ptr <= RESET_VALUE;
    else         ptr <= ptr_nxt;
  end

`ifdef ADDRESS_POINTER_WRAP_FLAG_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wrapped <= 1'b0;
    end else if (!loadn || !lo_loadn || !hi_loadn) begin
      wrapped <= 1'b0;
    end else if ((do_inc && inc_val[16]) || (do_dec && dec_val[16])) begin
      wrapped <= 1'b1;
    end
  end
`endif

  // Tri-state drivers; the bus always shows the registered value, so a
  // same-cycle load from a bus this block drives is a self-reload.
  assign abus = !outn    ? ptr        : 16'bz;
  assign mbus = !lo_outn ? ptr[7:0]   :
                !hi_outn ? ptr[15:8]  : 8'bz;

endmodule

// File: tb/tb_address_pointer.sv
module tb_address_pointer;

  logic        clk;
  logic        resetn;
  logic        loadn, lo_loadn, hi_loadn, incn, decn;
  logic        outn, lo_outn, hi_outn;
  logic        tb_abus_en, tb_mbus_en;
  logic [15:0] tb_abus;
  logic [7:0]  tb_mbus;
  wire  [15:0] abus;
  wire  [7:0]  mbus;
`ifdef ADDRESS_POINTER_WRAP_FLAG_EN
  logic        wrapped;
`endif

  int total = 0;
  int bad   = 0;
  bit conflict_seen = 1'b0;

  assign abus = tb_abus_en ? tb_abus : 16'bz;
  assign mbus = tb_mbus_en ? tb_mbus : 8'bz;

  address_pointer #(.RESET_VALUE(16'h0000), .STEP(1)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .abus     (abus),
    .mbus     (mbus),
    .loadn    (loadn),
    .lo_loadn (lo_loadn),
    .hi_loadn (hi_loadn),
    .incn     (incn),
    .decn     (decn),
    .outn     (outn),
    .lo_outn  (lo_outn),
    .hi_outn  (hi_outn)
`ifdef ADDRESS_POINTER_WRAP_FLAG_EN
    ,
    .wrapped  (wrapped)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Both byte out-enables together is an illegal use of mbus.
  always @(negedge clk) if (!lo_outn && !hi_outn) conflict_seen = 1'b1;

  typedef struct {
    string       name;
    logic        loadn, lo_loadn, hi_loadn, incn, decn;
    logic [15:0] abus_val;
    logic [7:0]  mbus_val;
    logic [15:0] exp_ptr;
    logic        exp_wrap;
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mk(string n, logic l, logic ll, logic hl, logic i, logic d,
                              logic [15:0] av, logic [7:0] mv, logic [15:0] e, logic w);
    vec_t v;
    v.name = n; v.loadn = l; v.lo_loadn = ll; v.hi_loadn = hl; v.incn = i; v.decn = d;
    v.abus_val = av; v.mbus_val = mv; v.exp_ptr = e; v.exp_wrap = w;
    return v;
  endfunction

  task automatic check16(string n, logic [15:0] act, logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic check8(string n, logic [7:0] act, logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  // A released net reads as z in a 4-state simulator and as 0 in a 2-state one;
  // callers only use this while the register holds a nonzero value.
  task automatic check_float16(string n, logic [15:0] act);
    total++;
    if (!(act === 16'hzzzz || act === 16'h0000)) begin
      bad++;
      $display("FAIL %s: got %h expected released bus", n, act);
    end
  endtask

  task automatic check_float8(string n, logic [7:0] act);
    total++;
    if (!(act === 8'hzz || act === 8'h00)) begin
      bad++;
      $display("FAIL %s: got %h expected released bus", n, act);
    end
  endtask

  task automatic idle();
    loadn = 1; lo_loadn = 1; hi_loadn = 1; incn = 1; decn = 1;
    tb_abus_en = 0; tb_mbus_en = 0;
  endtask

  // Inputs change 2 time units after a rising edge, well clear of both edges.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic read_ptr(string n, logic [15:0] exp);
    outn = 0;
    #1;
    check16(n, abus, exp);
    outn = 1;
  endtask

  task automatic apply(vec_t v);
    loadn = v.loadn; lo_loadn = v.lo_loadn; hi_loadn = v.hi_loadn;
    incn = v.incn; decn = v.decn;
    tb_abus = v.abus_val; tb_abus_en = !v.loadn;
    tb_mbus = v.mbus_val; tb_mbus_en = !v.lo_loadn || !v.hi_loadn;
    tick();
    idle();
  endtask

  task automatic load_word(logic [15:0] val);
    apply(mk("ld", 0, 1, 1, 1, 1, val, 8'h00, 16'h0, 1'b0));
  endtask

  initial begin
    resetn = 0; outn = 1; lo_outn = 1; hi_outn = 1;
    tb_abus = '0; tb_mbus = '0;
    idle();

    //                name          ld ll hl in dc  abus      mbus   exp       w
    vecs[0]  = mk("word_load",      0, 1, 1, 1, 1, 16'hFCE1, 8'h00, 16'hFCE1, 0);
    vecs[1]  = mk("lo_load",        1, 0, 1, 1, 1, 16'h0000, 8'hA8, 16'hFCA8, 0);
    vecs[2]  = mk("hi_load",        1, 1, 0, 1, 1, 16'h0000, 8'h12, 16'h12A8, 0);
    vecs[3]  = mk("inc",            1, 1, 1, 0, 1, 16'h0000, 8'h00, 16'h12A9, 0);
    vecs[4]  = mk("dec",            1, 1, 1, 1, 0, 16'h0000, 8'h00, 16'h12A8, 0);
    vecs[5]  = mk("inc_dec_hold",   1, 1, 1, 0, 0, 16'h0000, 8'h00, 16'h12A8, 0);
    vecs[6]  = mk("both_byte_load", 1, 0, 0, 1, 1, 16'h0000, 8'h5A, 16'h5A5A, 0);
    vecs[7]  = mk("load_ffff",      0, 1, 1, 1, 1, 16'hFFFF, 8'h00, 16'hFFFF, 0);
    vecs[8]  = mk("inc_wrap",       1, 1, 1, 0, 1, 16'h0000, 8'h00, 16'h0000, 1);
    vecs[9]  = mk("dec_wrap",       1, 1, 1, 1, 0, 16'h0000, 8'h00, 16'hFFFF, 1);
    vecs[10] = mk("load_clears",    0, 1, 1, 1, 1, 16'h0005, 8'h00, 16'h0005, 0);
    vecs[11] = mk("dec_nowrap",     1, 1, 1, 1, 0, 16'h0000, 8'h00, 16'h0004, 0);
    vecs[12] = mk("load_0100",      0, 1, 1, 1, 1, 16'h0100, 8'h00, 16'h0100, 0);
    vecs[13] = mk("load_over_inc",  0, 1, 1, 0, 1, 16'h2000, 8'h00, 16'h2000, 0);
    vecs[14] = mk("inc_dec_hold2",  1, 1, 1, 0, 0, 16'h0000, 8'h00, 16'h2000, 0);
    vecs[15] = mk("lo_over_dec",    1, 0, 1, 1, 0, 16'h0000, 8'h77, 16'h2077, 0);
    vecs[16] = mk("hi_over_inc",    1, 1, 0, 0, 1, 16'h0000, 8'h3C, 16'h3C77, 0);

    // Reset state, visible without any clock edge.
    #2;
    read_ptr("reset_value", 16'h0000);
`ifdef ADDRESS_POINTER_WRAP_FLAG_EN
    total++;
    if (wrapped !== 1'b0) begin bad++; $display("FAIL reset_wrapped: got %b expected 0", wrapped); end
`endif
    #1 resetn = 1;
    tick();

    foreach (vecs[k]) begin
      apply(vecs[k]);
      read_ptr(vecs[k].name, vecs[k].exp_ptr);
`ifdef ADDRESS_POINTER_WRAP_FLAG_EN
      total++;
      if (wrapped !== vecs[k].exp_wrap) begin
        bad++;
        $display("FAIL %s_wrapped: got %b expected %b", vecs[k].name, wrapped, vecs[k].exp_wrap);
      end
`endif
    end

    // Asynchronous reset between edges, then reset held across an increment edge.
    load_word(16'h1234);
    read_ptr("pre_reset", 16'h1234);
    outn = 0;
    resetn = 0;
    #1;
    check16("async_reset", abus, 16'h0000);
    outn = 1;
    load_word(16'h4321);
    read_ptr("load_during_reset", 16'h0000);
    incn = 0;
    tick();
    idle();
    read_ptr("inc_during_reset", 16'h0000);
    resetn = 1;
    tick();

    // Word out-enable and release.
    load_word(16'hFCE1);
    outn = 0;
    #1 check16("abus_drive", abus, 16'hFCE1);
    outn = 1;
    #1 check_float16("abus_release", abus);

    // Byte outputs.
    apply(mk("lo", 1, 0, 1, 1, 1, 16'h0, 8'hA8, 16'h0, 0));
    apply(mk("hi", 1, 1, 0, 1, 1, 16'h0, 8'h12, 16'h0, 0));
    read_ptr("byte_loads", 16'h12A8);
    hi_outn = 0;
    #1 check8("mbus_hi", mbus, 8'h12);
    hi_outn = 1;
    lo_outn = 0;
    #1 check8("mbus_lo", mbus, 8'hA8);
    // Self-reload of the low byte while it drives mbus.
    lo_loadn = 0;
    tick();
    idle();
    lo_outn = 1;
    #1 check_float8("mbus_release", mbus);
    read_ptr("lo_self_reload", 16'h12A8);

    // Word self-reload while driving abus.
    outn = 0;
    loadn = 0;
    tick();
    idle();
    #1 check16("word_self_reload", abus, 16'h12A8);
    outn = 1;

    // Post-increment read: old value before the edge, new value after it.
    load_word(16'h00FF);
    outn = 0;
    incn = 0;
    #1 check16("post_inc_before", abus, 16'h00FF);
    tick();
    incn = 1;
    check16("post_inc_after", abus, 16'h0100);
    outn = 1;

    total++;
    if (conflict_seen) begin
      bad++;
      $display("FAIL mbus_conflict: got 1 expected 0");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
